// File: rtl/pix_count_pkg.sv
// Shared types and arithmetic for the multi-channel pixel counter.
// sat_add works at a fixed 32-bit container width; callers pass their real accumulator width.
package pix_count_pkg;

  localparam int CH_DEF    = 4;
  localparam int INC_W_DEF = 4;
  localparam int SUM_W_DEF = 15;
  localparam int MAX_W     = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] sum;
  } add_res_t;

  // Overflow means the true sum no longer fits in sum_w bits.
  function automatic add_res_t sat_add(input logic [MAX_W-1:0] acc,
                                       input logic [MAX_W-1:0] inc,
                                       input int               sum_w,
                                       input logic             saturate);
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] max_val;
    add_res_t         res;
    max_val = {MAX_W{1'b1}} >> (MAX_W - sum_w);
    full    = {1'b0, acc} + {1'b0, inc};
    res.ovf = (full > {1'b0, max_val});
    if (!res.ovf)
      res.sum = full[MAX_W-1:0];
    else if (saturate)
      res.sum = max_val;
    else
      res.sum = full[MAX_W-1:0] & max_val;
    return res;
  endfunction

endpackage

// File: rtl/pix_count_accum_ch.sv
// One counter channel: accumulator with sticky overflow, saturate or wrap add,
// and restart on frame end or clear.
module count_ch_acc
  import pix_count_pkg::*;
#(
  parameter int INC_W    = INC_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             add_en,
  input  logic             restart,
  input  logic [INC_W-1:0] inc,
  output logic [SUM_W-1:0] acc,
  output logic [SUM_W-1:0] acc_next,
  output logic             ovf_next
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  add_res_t         res;
  logic             unused_hi;

  // acc_next/ovf_next are the post-add values, which is what a frame-end snapshot captures.
  always_comb begin
    res      = sat_add(MAX_W'(acc_q), MAX_W'(inc), SUM_W, SATURATE);
    acc_next = acc_q;
    ovf_next = ovf_q;
    if (add_en) begin
      acc_next = res.sum[SUM_W-1:0];
      ovf_next = ovf_q | res.ovf;
    end
    acc_d = acc_next;
    ovf_d = ovf_next;
    if (clr || (add_en && restart)) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign unused_hi = ^res.sum[MAX_W-1:SUM_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pix_count_accum.sv
// Multi-channel per-frame accumulator: input register stage, NUM_CH counter
// channels, and a one-deep snapshot register with valid/ready handshake.
module pix_count_accum
  import pix_count_pkg::*;
#(
  parameter int NUM_CH   = CH_DEF,
  parameter int INC_W    = INC_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [NUM_CH*INC_W-1:0] inc_vec,
  input  logic                    frame_end,
  output logic [NUM_CH*SUM_W-1:0] run_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*SUM_W-1:0] out_sum,
  output logic [NUM_CH-1:0]       out_ovf,
  output logic                    overrun
);

  logic [NUM_CH*INC_W-1:0] inc_q, inc_d;
  logic                    v_q, v_d;
  logic                    fe_q, fe_d;
  logic                    snap;
  logic [NUM_CH*SUM_W-1:0] snap_sum;
  logic [NUM_CH-1:0]       snap_ovf;

  out_state_e              state_q, state_d;
  logic [NUM_CH*SUM_W-1:0] out_sum_q, out_sum_d;
  logic [NUM_CH-1:0]       out_ovf_q, out_ovf_d;
  logic                    overrun_q, overrun_d;
  logic                    load;

  always_comb begin
    inc_d = inc_q;
    v_d   = 1'b0;
    fe_d  = 1'b0;
    if (clr) begin
      inc_d = '0;
    end else if (in_valid) begin
      inc_d = inc_vec;
      v_d   = 1'b1;
      fe_d  = frame_end;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_q <= '0;
      v_q   <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      inc_q <= inc_d;
      v_q   <= v_d;
      fe_q  <= fe_d;
    end
  end

  // A clear on the frame-end edge discards the pending snapshot too.
  assign snap = v_q & fe_q & ~clr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    count_ch_acc #(
      .INC_W   (INC_W),
      .SUM_W   (SUM_W),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .add_en  (v_q),
      .restart (fe_q),
      .inc     (inc_q[c*INC_W +: INC_W]),
      .acc     (run_sum[c*SUM_W +: SUM_W]),
      .acc_next(snap_sum[c*SUM_W +: SUM_W]),
      .ovf_next(snap_ovf[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (snap) state_d = FULL;
      FULL:    if (out_ready) state_d = snap ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // A full, unread holder keeps its data; the newer snapshot is dropped and flagged.
  always_comb begin
    out_valid = (state_q == FULL);
    load      = snap && (!out_valid || out_ready);
    out_sum_d = load ? snap_sum : out_sum_q;
    out_ovf_d = load ? snap_ovf : out_ovf_q;
    overrun_d = overrun_q | (snap & out_valid & ~out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sum_q <= '0;
      out_ovf_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_sum = out_sum_q;
  assign out_ovf = out_ovf_q;
  assign overrun = overrun_q;

endmodule

// File: doc/pix_count_accum.md
Name: pix_count_accum

Overview:
- Multi-channel, parametrised pixel/feature counter for the image-sorting datapath.
- Each channel accumulates a multi-bit increment per valid cycle, with a selectable saturate or wrap mode and per-channel overflow flags.
- At frame end it snapshots all channel totals into an output holding register with a valid/ready handshake, and restarts counting with no dead cycle.
- Feeds the sort/compare stage with per-frame histogram-style totals.

Parameters:
- NUM_CH, 4, number of independent counter channels.
- INC_W, 4, width of each channel's increment (unsigned).
- SUM_W, 15, width of each accumulator (unsigned).
- SATURATE, 1, 1 = clamp at 2^SUM_W-1; 0 = wrap modulo 2^SUM_W.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of the counting pipeline (priority below reset).
- in_valid  input  1  inc_vec qualifier.
- inc_vec  input  NUM_CH*INC_W  per-channel increments; channel c occupies bits [c*INC_W +: INC_W].
- frame_end  input  1  marks the current in_valid beat as the last of the frame; ignored when in_valid=0.
- run_sum  output  NUM_CH*SUM_W  live accumulator values (registered).
- out_valid  output  1  snapshot available.
- out_ready  input  1  consumer accepts snapshot.
- out_sum  output  NUM_CH*SUM_W  snapshotted frame totals.
- out_ovf  output  NUM_CH  per-channel overflow flags for the snapshotted frame.
- overrun  output  1  sticky: a snapshot was lost because the holding register was full.

Behaviour:
- Reset (async): inc_q, fe_q, v_q, acc, ovf, out_sum, out_ovf, out_valid and overrun all 0.

Pipeline (2 stages):
- Edge N: if in_valid, register inc_q <= inc_vec, v_q <= 1, fe_q <= frame_end; otherwise v_q <= 0 and fe_q <= 0.
- Edge N+1: if v_q, acc[c] <= f(acc[c] + inc_q[c]).
- Latency from in_valid sample to run_sum update: 2 edges.

Arithmetic:
- Compute the sum at SUM_W+1 bits.
- If the carry bit is set:
  - SATURATE=1: result = all-ones.
  - SATURATE=0: result = low SUM_W bits.
  - In either mode, ovf[c] <= 1 (sticky until the frame restarts).
- A channel already at max with SATURATE=1 stays at max and ovf stays 1.

Frame end (v_q=1 and fe_q=1 at edge N+1):
- The snapshot takes the post-add values, i.e. the last beat is included.
- out_sum <= acc_next and out_ovf <= ovf_next.
- On the same edge, acc <= 0 and ovf <= 0. Data arriving on the next edge counts toward the new frame.

Output handshake (states EMPTY / FULL, encoded by out_valid):
- EMPTY + snapshot: load the snapshot, go to FULL.
- FULL + out_ready=1: consume. If a new snapshot arrives on the same edge, load it and stay FULL; otherwise go to EMPTY.
- FULL + out_ready=0 + new snapshot: keep the old data, drop the new one, set overrun <= 1. overrun clears only on reset.
- out_sum/out_ovf are stable while out_valid=1 and out_ready=0.

clr (synchronous):
- Zeroes inc_q, v_q, fe_q, acc and ovf. Any in-flight beat is discarded, including a pending frame_end.
- Does not touch the output register, out_valid or overrun.
- If in_valid=1 in the same cycle as clr, that beat is discarded as well.

Other cases:
- frame_end with in_valid=0: no effect.
- Back-to-back frame_end beats: single-beat frames are legal; each produces a snapshot.
- Reset mid-frame: everything returns to reset values immediately; there is no partial snapshot.

Decomposition:
- Shared package pix_count_pkg holds:
  - default constants CH_DEF=4, INC_W_DEF=4, SUM_W_DEF=15;
  - a function sat_add(acc, inc, saturate) returning {ovf, sum};
  - the output state encoding EMPTY/FULL.
- Sub-module count_ch_acc: one channel (acc register, sticky ovf, sat/wrap add, clear-on-frame-end/clr). Instantiated NUM_CH times via generate.
- The top level holds the input pipeline, snapshot register and handshake.

Test Plan:
- Defaults; 10 beats with inc_vec channel values {1,2,3,15} per beat, frame_end on beat 10 -> out_valid=1, out_sum = {10,20,30,150}, out_ovf=0; run_sum=0 the cycle after the snapshot.
- SATURATE=1, SUM_W=8, ch0 inc=15 for 20 beats -> ch0 stays at 255 after beat 17, out_ovf[0]=1, other channels unaffected.
- SATURATE=0, SUM_W=8, ch0 inc=15 for 18 beats -> out_sum[0] = 270 mod 256 = 14, out_ovf[0]=1.
- Hold out_ready=0 across two frame_ends -> first snapshot retained unchanged, overrun=1. Then out_ready=1 -> out_valid drops next edge; overrun stays 1.
- Frame with 5 beats of inc=1, then clr on cycle 3 -> run_sum=0 after clr, and only beats after clr are counted. The final snapshot equals the post-clr beat count; out_valid from a prior frame is unaffected.
- Assert reset mid-frame with out_valid=1 -> all outputs 0 asynchronously. After release, a fresh 3-beat frame with inc=2 -> out_sum=6.
